// File: rtl/xadac_pkg.sv
// Shared definitions for the xadac vector multiply-accumulate execute unit:
// signedness mode encoding, the saturate control bit and lane geometry helpers.
package xadac_pkg;

    // Signedness of the two multiplicands, written as vs1*vs2
    typedef enum logic [1:0] {
        VMACC_SU = 2'b00,
        VMACC_UU = 2'b01,
        VMACC_SS = 2'b10,
        VMACC_US = 2'b11
    } vmacc_mode_e;

    // Bit of req_mode that selects clamping instead of wrap-around
    localparam int unsigned VMACC_SAT_BIT = 2;

    function automatic int unsigned lane_count(int unsigned vector_width, int unsigned sum_width);
        return vector_width / sum_width;
    endfunction

    function automatic int unsigned elems_per_lane(int unsigned sum_width, int unsigned elem_width);
        return sum_width / elem_width;
    endfunction

    function automatic logic vs1_is_signed(vmacc_mode_e m);
        return (m == VMACC_SU) || (m == VMACC_SS);
    endfunction

    function automatic logic vs2_is_signed(vmacc_mode_e m);
        return (m == VMACC_SS) || (m == VMACC_US);
    endfunction

endpackage

// File: rtl/xadac_vmacc_pipe_if.sv
// Request/response channel between the xadac issue logic (master) and the
// vector multiply-accumulate execute slot (slave).
interface xadac_vmacc_pipe_if #(
    parameter int VectorWidth = 128,
    parameter int IdWidth     = 4,
    parameter int ImmWidth    = 8
);
    logic                   req_valid;
    logic                   req_ready;
    logic [IdWidth-1:0]     req_id;
    logic [ImmWidth-1:0]    req_imm;
    logic [2:0]             req_mode;
    logic [VectorWidth-1:0] req_vs1;
    logic [VectorWidth-1:0] req_vs2;
    logic [VectorWidth-1:0] req_vs3;

    logic                   resp_valid;
    logic                   resp_ready;
    logic [IdWidth-1:0]     resp_id;
    logic [VectorWidth-1:0] resp_vd;
    logic [31:0]            resp_rd;

    modport master (
        output req_valid, req_id, req_imm, req_mode, req_vs1, req_vs2, req_vs3, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_vd, resp_rd
    );

    modport slave (
        input  req_valid, req_id, req_imm, req_mode, req_vs1, req_vs2, req_vs3, resp_ready,
        output req_ready, resp_valid, resp_id, resp_vd, resp_rd
    );
endinterface

// File: rtl/xadac_vmacc_lane.sv
// One accumulator lane. The product half forms the J-limited element products
// (inactive elements contribute zero); the reduce half adds the products to the
// accumulator input and optionally clamps to the signed lane range. The two
// halves are independent so the top can place a register between them.
module xadac_vmacc_lane
    import xadac_pkg::*;
#(
    parameter  int ElemWidth = 8,
    parameter  int SumWidth  = 32,
    localparam int Jmax      = int'(elems_per_lane(SumWidth, ElemWidth)),
    localparam int JW        = $clog2(Jmax + 1),
    localparam int PW        = 2 * ElemWidth + 2
) (
    input  logic [SumWidth-1:0] vs1,
    input  logic [SumWidth-1:0] vs2,
    input  vmacc_mode_e         mode,
    input  logic [JW-1:0]       j,
    output logic [Jmax*PW-1:0]  prod,
    input  logic [Jmax*PW-1:0]  prod_q,
    input  logic [SumWidth-1:0] acc,
    input  logic                sat,
    output logic [SumWidth-1:0] res
);
    // Wide enough that the accumulator plus every product can never overflow
    localparam int AW = SumWidth + $clog2(Jmax) + 2 + ElemWidth;
    localparam logic signed [AW-1:0] SatMax = {{(AW-SumWidth+1){1'b0}}, {(SumWidth-1){1'b1}}};
    localparam logic signed [AW-1:0] SatMin = {{(AW-SumWidth+1){1'b1}}, {(SumWidth-1){1'b0}}};

    logic s1;
    logic s2;
    logic signed [AW-1:0] total;

    assign s1 = vs1_is_signed(mode);
    assign s2 = vs2_is_signed(mode);

    for (genvar k = 0; k < Jmax; k++) begin : g_elem
        logic [ElemWidth-1:0]      ea;
        logic [ElemWidth-1:0]      eb;
        logic signed [ElemWidth:0] xa;
        logic signed [ElemWidth:0] xb;

        assign ea = vs1[k*ElemWidth +: ElemWidth];
        assign eb = vs2[k*ElemWidth +: ElemWidth];
        assign xa = {s1 & ea[ElemWidth-1], ea};
        assign xb = {s2 & eb[ElemWidth-1], eb};
        assign prod[k*PW +: PW] = (JW'(k) < j) ? PW'(xa) * PW'(xb) : '0;
    end

    // Sum the accumulator and all product slots at full precision
    always_comb begin
        total = AW'($signed(acc));
        for (int k = 0; k < Jmax; k++) begin
            total = total + AW'($signed(prod_q[k*PW +: PW]));
        end
    end

    // Either keep the low lane bits or clamp to the signed lane range
    always_comb begin
        res = total[SumWidth-1:0];
        if (sat && (total > SatMax)) begin
            res = SatMax[SumWidth-1:0];
        end else if (sat && (total < SatMin)) begin
            res = SatMin[SumWidth-1:0];
        end
    end

endmodule

// File: rtl/xadac_vmacc_pipe.sv
// Pipelined vector multiply-accumulate execute unit. Stage 0 holds the
// element products; the remaining stages carry the finished lane results
// toward the output register. Every stage stalls independently under
// resp_ready back-pressure, so bubbles are squeezed out.
module xadac_vmacc_pipe
    import xadac_pkg::*;
#(
    parameter int VectorWidth = 128,
    parameter int ElemWidth   = 8,
    parameter int SumWidth    = 32,
    parameter int Stages      = 2,
    parameter int IdWidth     = 4,
    parameter int ImmWidth    = 8
) (
    input  logic              clk,
    input  logic              rst,
    xadac_vmacc_pipe_if.slave bus
);
    localparam int Lanes = int'(lane_count(VectorWidth, SumWidth));
    localparam int Jmax  = int'(elems_per_lane(SumWidth, ElemWidth));
    localparam int PW    = 2 * ElemWidth + 2;
    localparam int JW    = $clog2(Jmax + 1);
    localparam int LPW   = Jmax * PW;

    logic [Stages-1:0]      v;
    logic [Stages-1:0]      ready;
    logic                   accept;
    logic [IdWidth-1:0]     id_q [Stages];
    logic [JW-1:0]          j_in;
    logic [Lanes*LPW-1:0]   prod_c;
    logic [Lanes*LPW-1:0]   prod_s;
    logic [VectorWidth-1:0] acc_s;
    logic                   sat_s;
    logic [VectorWidth-1:0] res_c;
    logic [VectorWidth-1:0] vd_out;

    // A stage can take new data unless it and everything after it is full and the output is stuck
    for (genvar k = 0; k < Stages; k++) begin : g_ready
        assign ready[k] = bus.resp_ready || !(&v[Stages-1:k]);
    end

    assign accept        = bus.req_valid && ready[0];
    assign bus.req_ready = ready[0];
    assign j_in          = (bus.req_imm > ImmWidth'(Jmax)) ? JW'(Jmax) : JW'(bus.req_imm);

    for (genvar i = 0; i < Lanes; i++) begin : g_lane
        xadac_vmacc_lane #(
            .ElemWidth(ElemWidth),
            .SumWidth (SumWidth)
        ) u_lane (
            .vs1   (bus.req_vs1[i*SumWidth +: SumWidth]),
            .vs2   (bus.req_vs2[i*SumWidth +: SumWidth]),
            .mode  (vmacc_mode_e'(bus.req_mode[1:0])),
            .j     (j_in),
            .prod  (prod_c[i*LPW +: LPW]),
            .prod_q(prod_s[i*LPW +: LPW]),
            .acc   (acc_s[i*SumWidth +: SumWidth]),
            .sat   (sat_s),
            .res   (res_c[i*SumWidth +: SumWidth])
        );
    end

    // Valid bits and transaction IDs move together through every stage
    always_ff @(posedge clk) begin
        if (rst) begin
            v <= '0;
            for (int k = 0; k < Stages; k++) begin
                id_q[k] <= '0;
            end
        end else begin
            if (ready[0]) begin
                v[0] <= bus.req_valid;
            end
            if (accept) begin
                id_q[0] <= bus.req_id;
            end
            for (int k = 1; k < Stages; k++) begin
                if (ready[k]) begin
                    v[k] <= v[k-1];
                end
                if (ready[k] && v[k-1]) begin
                    id_q[k] <= id_q[k-1];
                end
            end
        end
    end

    if (Stages == 1) begin : g_single
        logic [VectorWidth-1:0] vd_q;

        assign prod_s = prod_c;
        assign acc_s  = bus.req_vs3;
        assign sat_s  = bus.req_mode[VMACC_SAT_BIT];
        assign vd_out = vd_q;

        // Whole computation lands in the single output register
        always_ff @(posedge clk) begin
            if (rst) begin
                vd_q <= '0;
            end else if (accept) begin
                vd_q <= res_c;
            end
        end
    end else begin : g_multi
        logic [Lanes*LPW-1:0]   prod_q;
        logic [VectorWidth-1:0] acc_q;
        logic                   sat_q;
        logic [VectorWidth-1:0] vd_q [Stages-1];

        assign prod_s = prod_q;
        assign acc_s  = acc_q;
        assign sat_s  = sat_q;
        assign vd_out = vd_q[Stages-2];

        // Stage 0 captures masked products, accumulator input and saturate control
        always_ff @(posedge clk) begin
            if (rst) begin
                prod_q <= '0;
                acc_q  <= '0;
                sat_q  <= 1'b0;
            end else if (accept) begin
                prod_q <= prod_c;
                acc_q  <= bus.req_vs3;
                sat_q  <= bus.req_mode[VMACC_SAT_BIT];
            end
        end

        // Stage 1 stores the reduced result; later stages pass it along untouched
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k < Stages - 1; k++) begin
                    vd_q[k] <= '0;
                end
            end else begin
                if (ready[1] && v[0]) begin
                    vd_q[0] <= res_c;
                end
                for (int k = 1; k < Stages - 1; k++) begin
                    if (ready[k+1] && v[k]) begin
                        vd_q[k] <= vd_q[k-1];
                    end
                end
            end
        end
    end

    assign bus.resp_valid = v[Stages-1];
    assign bus.resp_id    = id_q[Stages-1];
    assign bus.resp_vd    = vd_out;
    assign bus.resp_rd    = '0;

endmodule

// File: tb/tb_xadac_vmacc_pipe.sv
// Self-checking bench for xadac_vmacc_pipe: directed arithmetic cases, random
// streaming, back-pressure and mid-flight reset, scored against a plain
// integer reference model and an in-order expectation queue.
module tb_xadac_vmacc_pipe;
    localparam int VW   = 128;
    localparam int EW   = 8;
    localparam int SW   = 32;
    localparam int ST   = 2;
    localparam int IW   = 4;
    localparam int MW   = 8;
    localparam int NL   = VW / SW;
    localparam int JMAX = SW / EW;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    typedef struct {
        logic [IW-1:0] id;
        logic [VW-1:0] vd;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    exp_t exp_q[$];
    int   n_pass   = 0;
    int   n_checks = 0;
    int   n_out    = 0;

    always #5 clk = ~clk;

    xadac_vmacc_pipe_if #(.VectorWidth(VW), .IdWidth(IW), .ImmWidth(MW)) bus ();

    xadac_vmacc_pipe #(
        .VectorWidth(VW),
        .ElemWidth  (EW),
        .SumWidth   (SW),
        .Stages     (ST),
        .IdWidth    (IW),
        .ImmWidth   (MW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    function automatic logic [VW-1:0] vmacc_model(logic [VW-1:0] a, logic [VW-1:0] b,
                                                  logic [VW-1:0] c, logic [MW-1:0] imm,
                                                  logic [2:0] mode);
        logic [VW-1:0] r;
        logic [EW-1:0] ea;
        logic [EW-1:0] eb;
        longint s;
        longint x;
        longint y;
        int jn;
        jn = (imm > MW'(JMAX)) ? JMAX : int'(imm);
        r = '0;
        for (int i = 0; i < NL; i++) begin
            s = longint'($signed(c[i*SW +: SW]));
            for (int j = 0; j < jn; j++) begin
                ea = a[(i*JMAX+j)*EW +: EW];
                eb = b[(i*JMAX+j)*EW +: EW];
                x = (mode[1:0] == 2'b00 || mode[1:0] == 2'b10) ? longint'($signed(ea)) : longint'(ea);
                y = (mode[1:0] == 2'b10 || mode[1:0] == 2'b11) ? longint'($signed(eb)) : longint'(eb);
                s = s + x * y;
            end
            if (mode[2]) begin
                if (s > SMAX) s = SMAX;
                else if (s < SMIN) s = SMIN;
            end
            r[i*SW +: SW] = s[SW-1:0];
        end
        return r;
    endfunction

    task automatic check_output(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic apply_stimulus(input logic valid, input logic [IW-1:0] id, input logic [MW-1:0] imm,
                                  input logic [2:0] mode, input logic [VW-1:0] a,
                                  input logic [VW-1:0] b, input logic [VW-1:0] c);
        bus.req_valid = valid;
        bus.req_id    = id;
        bus.req_imm   = imm;
        bus.req_mode  = mode;
        bus.req_vs1   = a;
        bus.req_vs2   = b;
        bus.req_vs3   = c;
    endtask

    function automatic logic [VW-1:0] rand_vec();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // One clock: score the output, record any acceptance, advance to the next falling edge
    task automatic step();
        exp_t e;
        #1;
        check_output("req_ready", VW'(bus.req_ready), VW'(bus.resp_ready || (exp_q.size() < ST)));
        if (bus.resp_valid) begin
            check_output("resp_expected", VW'(exp_q.size() > 0), VW'(1'b1));
            if (exp_q.size() > 0) begin
                check_output("resp_id", VW'(bus.resp_id), VW'(exp_q[0].id));
                check_output("resp_vd", bus.resp_vd, exp_q[0].vd);
                if (bus.resp_ready) begin
                    void'(exp_q.pop_front());
                    n_out++;
                end
            end
        end
        if (bus.req_valid && bus.req_ready) begin
            e.id = bus.req_id;
            e.vd = vmacc_model(bus.req_vs1, bus.req_vs2, bus.req_vs3, bus.req_imm, bus.req_mode);
            exp_q.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain(input int budget);
        int left;
        left = budget;
        bus.req_valid = 1'b0;
        while (exp_q.size() > 0 && left > 0) begin
            step();
            left--;
        end
        check_output("drain_done", VW'(exp_q.size()), VW'(0));
    endtask

    // Single request into an empty pipe: latency, ID echo and a known lane-0 value
    task automatic run_directed(input string tag, input logic [IW-1:0] id, input logic [MW-1:0] imm,
                                input logic [2:0] mode, input logic [VW-1:0] a, input logic [VW-1:0] b,
                                input logic [VW-1:0] c, input logic [SW-1:0] lane0);
        bus.resp_ready = 1'b1;
        apply_stimulus(1'b1, id, imm, mode, a, b, c);
        step();
        bus.req_valid = 1'b0;
        check_output({tag, "_lat1"}, VW'(bus.resp_valid), VW'(1'b0));
        step();
        check_output({tag, "_lat2"}, VW'(bus.resp_valid), VW'(1'b1));
        check_output({tag, "_id"}, VW'(bus.resp_id), VW'(id));
        check_output({tag, "_lane0"}, VW'(bus.resp_vd[SW-1:0]), VW'(lane0));
        step();
    endtask

    initial begin
        int base;
        rst = 1'b1;
        bus.resp_ready = 1'b0;
        apply_stimulus(1'b0, '0, '0, '0, '0, '0, '0);
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        check_output("rst_valid", VW'(bus.resp_valid), VW'(1'b0));
        check_output("rst_id", VW'(bus.resp_id), VW'(0));
        check_output("rst_vd", bus.resp_vd, VW'(0));
        check_output("rst_rd", VW'(bus.resp_rd), VW'(0));
        check_output("rst_ready", VW'(bus.req_ready), VW'(1'b1));
        rst = 1'b0;

        $display("[TB] directed arithmetic cases");
        run_directed("su_dot", 4'h9, 8'd4, 3'b000, VW'(32'h040302FF), VW'(32'h010101FF), VW'(32'd10), 32'hFFFFFF14);
        run_directed("imm2", 4'h1, 8'd2, 3'b001, {4{32'h05050505}}, {4{32'h03030303}}, {4{32'd1}}, 32'd31);
        run_directed("imm0", 4'h2, 8'd0, 3'b001, {4{32'h05050505}}, {4{32'h03030303}}, {4{32'd1}}, 32'd1);
        run_directed("imm200", 4'h3, 8'd200, 3'b001, {4{32'h05050505}}, {4{32'h03030303}}, {4{32'd1}}, 32'd61);
        run_directed("sat_ss", 4'h4, 8'd4, 3'b110, {4{32'h80808080}}, {4{32'h80808080}}, {4{32'h7FFFFF00}}, 32'h7FFFFFFF);
        run_directed("wrap_ss", 4'h5, 8'd4, 3'b010, {4{32'h80808080}}, {4{32'h80808080}}, {4{32'h7FFFFF00}}, 32'h8000FF00);
        run_directed("uu_max", 4'h6, 8'd4, 3'b001, {4{32'hFFFFFFFF}}, {4{32'hFFFFFFFF}}, '0, 32'h0003F804);
        run_directed("imm0_sat", 4'h7, 8'd0, 3'b110, {4{32'h80808080}}, {4{32'h80808080}}, {4{32'h80000000}}, 32'h80000000);

        $display("[TB] back-to-back streaming");
        base = n_out;
        bus.resp_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            apply_stimulus(1'b1, IW'(i), MW'($urandom_range(0, 6)), 3'($urandom_range(0, 7)),
                           rand_vec(), rand_vec(), rand_vec());
            step();
        end
        check_output("stream_mid_count", VW'(n_out - base), VW'(16 - ST));
        bus.req_valid = 1'b0;
        repeat (ST) step();
        check_output("stream_total", VW'(n_out - base), VW'(16));
        check_output("stream_empty", VW'(exp_q.size()), VW'(0));

        $display("[TB] back-pressure");
        base = n_out;
        bus.resp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(1'b1, IW'($urandom()), MW'($urandom_range(0, 8)), 3'($urandom_range(0, 7)),
                           rand_vec(), rand_vec(), rand_vec());
            step();
        end
        check_output("bp_accepted", VW'(exp_q.size()), VW'(ST));
        bus.resp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b1, IW'($urandom()), MW'($urandom_range(0, 8)), 3'($urandom_range(0, 7)),
                           rand_vec(), rand_vec(), rand_vec());
            step();
        end
        drain(10);
        check_output("bp_total", VW'(n_out - base), VW'(ST + 3));

        $display("[TB] reset with transactions in flight");
        bus.resp_ready = 1'b1;
        apply_stimulus(1'b1, 4'hA, 8'd4, 3'b010, rand_vec(), rand_vec(), rand_vec());
        step();
        apply_stimulus(1'b1, 4'hB, 8'd4, 3'b001, rand_vec(), rand_vec(), rand_vec());
        step();
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b0;
        rst = 1'b1;
        step();
        check_output("midrst_valid", VW'(bus.resp_valid), VW'(1'b0));
        check_output("midrst_vd", bus.resp_vd, VW'(0));
        check_output("midrst_id", VW'(bus.resp_id), VW'(0));
        check_output("midrst_ready", VW'(bus.req_ready), VW'(1'b1));
        exp_q.delete();
        rst = 1'b0;
        bus.resp_ready = 1'b1;
        repeat (3) step();
        run_directed("post_rst", 4'hC, 8'd4, 3'b000, VW'(32'h040302FF), VW'(32'h010101FF), VW'(32'd10), 32'hFFFFFF14);
        drain(5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
